// File: rtl/axis_hscaler_stream.sv
// rtl/axis_hscaler_stream.sv - horizontal nearest-neighbour line scaler on AXI-Stream
//
// Purpose: resamples one video line of s_nbr source pixels into m_nbr output
// pixels. Output pixel j is source pixel floor(j*s_nbr/m_nbr). The choice is
// made with an error accumulator instead of a divider.
//
// Ports:
//   clk, resetn        clock (rising edge), synchronous active-low reset
//   enable             allows a new line to start from IDLE
//   s_nbr, m_nbr       source / output pixels per line, latched at line start
//   s_axis_*           pixel input (tdata, tuser, tlast, tvalid; tready out)
//   m_axis_*           pixel output (tdata, tuser, tlast, tvalid; tready in)
//   line_err           one-cycle pulse when source tlast disagrees with s_nbr
//
// Build option: define HSCALER_LINE_CHECK_EN to enable the source tlast
// check. When it is undefined, line_err stays 0 and s_axis_tlast is unused.

module axis_hscaler_stream #(
  parameter int C_PIXEL_WIDTH = 24,
  parameter int C_S_WIDTH     = 12,
  parameter int C_M_WIDTH     = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [C_S_WIDTH-1:0]     s_nbr,
  input  logic [C_M_WIDTH-1:0]     m_nbr,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     line_err
);

  // Before each add, acc is below m_nbr. After the add it is below
  // s_nbr + m_nbr. One extra bit over the wider count is therefore enough.
  localparam int AW = ((C_S_WIDTH > C_M_WIDTH) ? C_S_WIDTH : C_M_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [C_S_WIDTH-1:0]     s_q, s_d;
  logic [C_M_WIDTH-1:0]     m_q, m_d;
  logic [AW-1:0]            acc_q, acc_d;
  logic [C_S_WIDTH-1:0]     src_cnt_q, src_cnt_d;
  logic [C_M_WIDTH-1:0]     out_cnt_q, out_cnt_d;
  logic [C_PIXEL_WIDTH-1:0] hold_q, hold_d;
  logic                     user_q, user_d;

  logic [AW-1:0]            s_ext, m_ext, acc_fetch, acc_emit;
  logic [C_S_WIDTH-1:0]     src_inc;
  logic                     last_out;

  assign s_ext     = AW'(s_q);
  assign m_ext     = AW'(m_q);
  assign src_inc   = src_cnt_q + C_S_WIDTH'(1);
  assign last_out  = (out_cnt_q == m_q - C_M_WIDTH'(1));
  // The first pixel of a line already lines up with output 0, so no subtract.
  assign acc_fetch = (src_cnt_q == '0) ? acc_q : acc_q - m_ext;
  assign acc_emit  = acc_q + s_ext;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      s_q       <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      src_cnt_q <= '0;
      out_cnt_q <= '0;
      hold_q    <= '0;
      user_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      src_cnt_q <= src_cnt_d;
      out_cnt_q <= out_cnt_d;
      hold_q    <= hold_d;
      user_q    <= user_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    m_d           = m_q;
    acc_d         = acc_q;
    src_cnt_d     = src_cnt_q;
    out_cnt_d     = out_cnt_q;
    hold_d        = hold_q;
    user_d        = user_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && (s_nbr != '0) && (m_nbr != '0)) begin
          s_d       = s_nbr;
          m_d       = m_nbr;
          acc_d     = '0;
          src_cnt_d = '0;
          out_cnt_d = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          hold_d    = s_axis_tdata;
          user_d    = s_axis_tuser;
          src_cnt_d = src_inc;
          acc_d     = acc_fetch;
          // If acc is still at or above m_nbr, this pixel is skipped.
          if (acc_fetch < m_ext) state_d = EMIT;
        end
      end
      EMIT: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) begin
          out_cnt_d = out_cnt_q + C_M_WIDTH'(1);
          acc_d     = acc_emit;
          if (last_out)               state_d = DRAIN;
          else if (acc_emit >= m_ext) state_d = FETCH;
        end
      end
      DRAIN: begin
        // Discard the unused source pixels so the next line starts aligned.
        if (src_cnt_q < s_q) begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) begin
            src_cnt_d = src_inc;
            if (src_inc == s_q) state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axis_tdata = hold_q;
  assign m_axis_tuser = (state_q == EMIT) && (out_cnt_q == '0) && user_q;
  assign m_axis_tlast = (state_q == EMIT) && last_out;

`ifdef HSCALER_LINE_CHECK_EN
  assign line_err = s_axis_tvalid && s_axis_tready &&
                    (s_axis_tlast != (src_cnt_q == s_q - C_S_WIDTH'(1)));
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign line_err     = 1'b0;
`endif

endmodule

// File: tb/tb_axis_hscaler_stream.sv
// tb/tb_axis_hscaler_stream.sv - directed self-checking bench for axis_hscaler_stream

module tb_axis_hscaler_stream;

  localparam int PW = 24;
  localparam int SW = 12;
  localparam int MW = 12;
`ifdef HSCALER_LINE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn, enable;
  logic [SW-1:0] s_nbr;
  logic [MW-1:0] m_nbr;
  logic          s_tvalid, s_tready, s_tuser, s_tlast;
  logic [PW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tuser, m_tlast;
  logic [PW-1:0] m_tdata;
  logic          line_err;

  int tests = 0;
  int fails = 0;
  int src_data [64];

  always #5 clk = ~clk;

  axis_hscaler_stream #(.C_PIXEL_WIDTH(PW), .C_S_WIDTH(SW), .C_M_WIDTH(MW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .s_nbr(s_nbr), .m_nbr(m_nbr),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata), .line_err(line_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, int'(m_tvalid), 0);
    check({tag, "_tready"}, int'(s_tready), 0);
    check({tag, "_tdata"},  int'(m_tdata),  0);
    check({tag, "_tuser"},  int'(m_tuser),  0);
    check({tag, "_tlast"},  int'(m_tlast),  0);
    check({tag, "_lineerr"}, int'(line_err), 0);
  endtask

  // Runs one line. Entered and left at 1 time unit after a rising edge.
  // rmode=1 gives random m_tready. err_at adds an extra source tlast.
  // abort_at>=0 asserts reset while output pixel abort_at is presented.
  task automatic run_line(input int s, input int m, input int rmode, input int err_at,
                          input int abort_at, input int rate_chk);
    int idx = 0, j = 0, cyc = 0, last_cyc = 0, bad = 0;
    bit done = 0, aborted = 0, stall = 0, s_hs;
    logic [PW-1:0] sd = '0;
    logic su = 1'b0, sl = 1'b0;
    s_nbr = SW'(s); m_nbr = MW'(m); enable = 1'b1;
    while (!done && cyc < 3000) begin
      s_tvalid = (idx < s);
      s_tdata  = PW'(src_data[idx]);
      s_tuser  = (idx == 0);
      s_tlast  = (idx == s - 1) || (idx == err_at);
      m_tready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (s_tready && m_tvalid) bad++;
      if (stall) begin
        check("stall_tvalid", int'(m_tvalid), 1);
        check("stall_tdata",  int'(m_tdata),  int'(sd));
        check("stall_tuser",  int'(m_tuser),  int'(su));
        check("stall_tlast",  int'(m_tlast),  int'(sl));
      end
      s_hs = s_tvalid && s_tready;
      check("line_err", int'(line_err), int'(CHK && s_hs && (s_tlast != (idx == s - 1))));
      if (abort_at >= 0 && m_tvalid && j == abort_at) begin
        m_tready = 1'b0;
        resetn   = 1'b0;
        aborted  = 1;
        done     = 1;
      end else if (m_tvalid && m_tready) begin
        check("out_tdata", int'(m_tdata), src_data[(j * s) / m]);
        check("out_tuser", int'(m_tuser), int'(j == 0));
        check("out_tlast", int'(m_tlast), int'(j == m - 1));
        if (j == 0 && rmode == 0) check("latency", cyc, 2);
        if (rate_chk != 0 && j > 0) check("rate", cyc - last_cyc, 2);
        last_cyc = cyc;
        j++;
      end
      stall = !aborted && m_tvalid && !m_tready;
      sd = m_tdata; su = m_tuser; sl = m_tlast;
      if (s_hs) idx++;
      if (j == m && idx == s) done = 1;
      tick();
      cyc++;
      // These values must be ignored until the line ends.
      if (cyc == 1) begin enable = 1'b0; s_nbr = SW'(1); m_nbr = MW'(1); end
    end
    if (!aborted) begin
      check("line_done", int'(done), 1);
      check("in_count", idx, s);
      check("out_count", j, m);
      check("overlap", bad, 0);
      s_tvalid = 1'b1;
      s_tdata  = PW'(src_data[0]);
      for (int k = 0; k < 3; k++) begin
        #1;
        check("idle_tready", int'(s_tready), 0);
        check("idle_tvalid", int'(m_tvalid), 0);
        tick();
      end
      s_tvalid = 1'b0;
    end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; s_nbr = '0; m_nbr = '0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    resetn = 1'b1;

    // A zero line length must not start a line.
    enable = 1'b1; s_nbr = '0; m_nbr = MW'(4); s_tvalid = 1'b1;
    repeat (3) tick();
    check("zero_len_tready", int'(s_tready), 0);
    check("zero_len_tvalid", int'(m_tvalid), 0);
    enable = 1'b0; s_tvalid = 1'b0;
    tick();

    // Upscale: 5 source pixels to 30 output pixels.
    for (int i = 0; i < 64; i++) src_data[i] = i + 1;
    run_line(5, 30, 0, -1, -1, 0);

    // Downscale: 30 source pixels to 5 output pixels.
    for (int i = 0; i < 64; i++) src_data[i] = i;
    run_line(30, 5, 0, -1, -1, 0);

    // Pass-through: one output every two cycles.
    for (int i = 0; i < 64; i++) src_data[i] = i + 10;
    run_line(8, 8, 0, -1, -1, 1);

    // Upscale with random output backpressure.
    for (int i = 0; i < 64; i++) src_data[i] = i + 1;
    run_line(5, 30, 1, -1, -1, 0);

    // Extra source tlast on pixel 2.
    run_line(5, 5, 0, 2, -1, 0);

    // Reset while output pixel 10 is presented, then a full line again.
    run_line(5, 30, 0, -1, 10, 0);
    check_all_zero("midreset");
    resetn = 1'b1;
    tick();
    run_line(5, 30, 0, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_hscaler_stream.md
AXIS_HSCALER_STREAM -- requirements
Module: axis_hscaler_stream

Interface
REQ-001 SHALL have parameter C_PIXEL_WIDTH, default 24, pixel data width in bits.
REQ-002 SHALL have parameter C_S_WIDTH, default 12, source line-length width.
REQ-003 SHALL have parameter C_M_WIDTH, default 12, output line-length width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable  input  1  permits start of a new line.
REQ-007 SHALL have ports s_nbr  input  C_S_WIDTH  source pixels per line; m_nbr  input  C_M_WIDTH  output pixels per line.
REQ-008 SHALL have ports s_axis_tvalid/tready/tuser/tlast (1 bit each) and s_axis_tdata (C_PIXEL_WIDTH), AXI-Stream slave, tready output.
REQ-009 SHALL have ports m_axis_tvalid/tready/tuser/tlast (1 bit each) and m_axis_tdata (C_PIXEL_WIDTH), AXI-Stream master, tready input.
REQ-010 SHALL have port line_err  output  1  one-cycle pulse on source line-length mismatch.

Function
REQ-011 SHALL perform horizontal nearest-neighbour resampling: output pixel j (0-based) equals source pixel floor(j*s_nbr/m_nbr).
REQ-012 SHALL implement states IDLE, FETCH, EMIT, DRAIN.
REQ-013 IDLE: tready=0, tvalid=0; when enable=1 and s_nbr!=0 and m_nbr!=0, latch s_nbr/m_nbr, clear acc/src_cnt/out_cnt, go FETCH.
REQ-014 FETCH: s_axis_tready=1; on handshake load hold register (tdata, tuser), src_cnt+=1, acc-=m_nbr unless first pixel of line; go EMIT when post-update acc<m_nbr, else stay FETCH.
REQ-015 EMIT: m_axis_tvalid=1, tdata=hold register; on handshake out_cnt+=1, acc+=s_nbr; if out_cnt was m_nbr-1 go DRAIN; else if new acc>=m_nbr go FETCH; else stay EMIT.
REQ-016 DRAIN: s_axis_tready=1 while src_cnt<s_nbr, discarding pixels; when src_cnt==s_nbr go IDLE (same cycle as last discard).
REQ-017 Accumulator SHALL be max(C_S_WIDTH,C_M_WIDTH)+1 bits; no overflow permitted.
REQ-018 m_axis_tuser SHALL be 1 only on output pixel 0 and only if source pixel 0 had tuser=1.
REQ-019 m_axis_tlast SHALL be 1 exactly on output pixel m_nbr-1.
REQ-020 m_axis_tvalid SHALL rise the cycle after the FETCH handshake that enters EMIT (latency 1).
REQ-021 While m_axis_tvalid=1 and tready=0, tdata/tuser/tlast SHALL hold stable.
REQ-022 enable/s_nbr/m_nbr changes mid-line SHALL be ignored until next IDLE.
REQ-023 s_nbr==m_nbr SHALL pass through one pixel per two cycles (FETCH/EMIT alternation).
REQ-024 s_axis_tready and m_axis_tvalid SHALL never both be 1 in the same cycle.

Reset
REQ-025 resetn=0 SHALL force IDLE, all outputs 0, counters/acc/hold register 0, from next edge, including mid-line.

Configuration
REQ-026 Macro HSCALER_LINE_CHECK_EN defined: on each source handshake, line_err pulses when tlast != (src_cnt==s_nbr-1); processing continues by count.
REQ-027 Macro undefined: line_err tied 0, s_axis_tlast ignored, check logic absent.

Verification
REQ-028 s_nbr=5, m_nbr=30, source 1..5, m_tready=1 -> 30 outputs, each value 6 times, tuser on #0, tlast on #29.
REQ-029 s_nbr=30, m_nbr=5, source 0..29 -> outputs 0,6,12,18,24; all 30 source pixels consumed; then IDLE.
REQ-030 s_nbr=m_nbr=8, source 10..17 -> outputs 10..17, one per 2 cycles.
REQ-031 Case REQ-028 with m_tready random 50% -> same sequence, data stable during stalls, no tvalid&tready&s_tready overlap.
REQ-032 Macro defined, s_nbr=5, tlast on source pixel 2 -> line_err one-cycle pulse at that handshake; macro undefined -> line_err 0.
REQ-033 resetn=0 during EMIT of pixel 10 -> next cycle all outputs 0, state IDLE; next line restarts at output 0.
